hex_write_arbiter: RTL and testbench
====================================

HEX_WRITE_ARBITER -- requirements
Module: hex_write_arbiter

Interface
REQ-001 Parameter: IDLE_GAP, default 2, number of idle cycles (0..15) enforced after each ack before the next grant.
REQ-002 Port: clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0  input  1  requester 0 update request, level, held until ack0.
REQ-005 Port: val0  input  8  requester 0 hex byte; high nibble drives HEX5, low nibble drives HEX4.
REQ-006 Port: ack0  output  1  one-cycle grant-complete pulse to requester 0.
REQ-007 Port: req1  input  1  requester 1 update request, same rules as req0.
REQ-008 Port: val1  input  8  requester 1 hex byte.
REQ-009 Port: ack1  output  1  one-cycle grant-complete pulse to requester 1.
REQ-010 Port: blank  input  1  when high at latch time, the written segment data is all zeros.
REQ-011 Port: avm_address  output  2  Avalon address to the HEX5_HEX4 PIO slave; constant 0.
REQ-012 Port: avm_chipselect  output  1  Avalon chipselect.
REQ-013 Port: avm_write_n  output  1  Avalon write strobe, active-low.
REQ-014 Port: avm_writedata  output  32  Avalon write data.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, ACK and GAP, and SHALL reset to IDLE.
REQ-017 IDLE transitions: any req high -> WRITE, latching the granted value, the blank level and the grant id; otherwise stay in IDLE.
REQ-018 WRITE lasts exactly 1 cycle with avm_chipselect=1 and avm_write_n=0, then goes to ACK; the slave has zero wait states.
REQ-019 ACK lasts 1 cycle with ack of the granted requester =1, then goes to GAP, or directly to IDLE if IDLE_GAP=0.
REQ-020 GAP counts IDLE_GAP cycles with a 4-bit down-counter, then goes to IDLE.
REQ-021 Latency: req sampled high in IDLE at edge N -> WRITE during cycle N+1 -> ack during cycle N+2.
REQ-022 Arbitration is round-robin: with both req high in IDLE, the requester not granted last wins; a single requester always wins.
REQ-023 A last_grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-024 Requesters hold req and val stable until ack, and drop req in the cycle after ack.
REQ-025 A req still high once the FSM returns to IDLE SHALL be treated as a new request.
REQ-026 avm_writedata SHALL be registered and formed as {16'b0, 1'b0, seg(hi nibble), 1'b0, seg(lo nibble)}; it is all zeros when blank is latched high.
REQ-027 seg() is active-high with bits 6..0 = g..a, mapping 0-F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-028 Outside WRITE: avm_chipselect=0, avm_write_n=1, avm_address=0.
REQ-029 At most one ack SHALL be high in any cycle, and neither is high outside ACK.
REQ-030 Changes on val or blank after the latch SHALL NOT affect the write in progress.

Reset
REQ-031 Reset asserted in any state SHALL immediately force IDLE, ack0=ack1=0, busy=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, last_grant=1 and the GAP counter to 0.
REQ-032 A grant interrupted by reset SHALL be dropped without an ack; a requester still holding req is re-arbitrated after reset deasserts.

Verification
REQ-033 req0=1, val0=0x3A, blank=0 -> one WRITE cycle with avm_writedata=0x00004F77, then ack0 pulse, with ack0 exactly 2 cycles after req0 is sampled.
REQ-034 req0 and req1 rise together after reset, val0=0x12, val1=0xEF -> first write 0x0000065B with ack0, then IDLE_GAP idle cycles, then write 0x00007971 with ack1.
REQ-035 req0 held high continuously with IDLE_GAP=2 -> writes spaced exactly 5 cycles apart, with busy low 1 cycle between them.
REQ-036 req1=1, val1=0x88, blank=1 -> write of 0x00000000 and ack1 pulse.
REQ-037 Reset asserted during WRITE -> chipselect drops the same cycle and no ack occurs; after release with req0 held, a normal write plus ack0 follows.
REQ-038 val0 changed during WRITE -> the written data reflects the value latched in IDLE.

Source files
------------

// File: rtl/hex_write_arbiter.sv
// hex_write_arbiter: round-robin arbiter for two requesters sharing the HEX5_HEX4 PIO slave.
// Rev 1.0 - initial release.
`default_nettype none

module hex_write_arbiter #(
  parameter int IDLE_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  val0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  val1,
  output logic        ack1,
  input  logic        blank,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  output logic        busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_ACK   = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  // Counter runs IDLE_GAP-1 down to 0, giving IDLE_GAP cycles in GAP.
  localparam logic [3:0] c_GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic        r_grant_id;
  logic [3:0]  r_gap_cnt;
  logic [31:0] r_writedata;

  logic        w_grant_valid;
  logic        w_grant_id;
  logic [7:0]  w_sel_val;
  logic [31:0] w_wdata;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    w_grant_valid = req0 | req1;
    w_grant_id    = (req0 & req1) ? ~r_last_grant : req1;
    w_sel_val     = w_grant_id ? val1 : val0;
    if (blank) begin
      w_wdata = 32'h0;
    end else begin
      w_wdata = {16'h0, 1'b0, seg7(w_sel_val[7:4]), 1'b0, seg7(w_sel_val[3:0])};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_gap_cnt    <= 4'd0;
      r_writedata  <= 32'h0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_valid) begin
            r_state      <= c_WRITE;
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_writedata  <= w_wdata;
          end
        end
        c_WRITE: r_state <= c_ACK;
        c_ACK: begin
          if (IDLE_GAP == 0) begin
            r_state <= c_IDLE;
          end else begin
            r_state   <= c_GAP;
            r_gap_cnt <= c_GAP_LOAD;
          end
        end
        c_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= c_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign avm_address    = 2'd0;
  assign avm_chipselect = (r_state == c_WRITE);
  assign avm_write_n    = ~(r_state == c_WRITE);
  assign avm_writedata  = r_writedata;
  assign ack0           = (r_state == c_ACK) & ~r_grant_id;
  assign ack1           = (r_state == c_ACK) &  r_grant_id;
  assign busy           = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hex_write_arbiter.sv
// tb_hex_write_arbiter: directed self-checking bench for hex_write_arbiter (IDLE_GAP = 2).
// Rev 1.0 - initial release.
`default_nettype none

module tb_hex_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [7:0]  val0;
  logic        ack0;
  logic        req1;
  logic [7:0]  val1;
  logic        ack1;
  logic        blank;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  hex_write_arbiter #(.IDLE_GAP(2)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .val0           (val0),
    .ack0           (ack0),
    .req1           (req1),
    .val1           (val1),
    .ack1           (ack1),
    .blank          (blank),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      step();
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  int first_cs;
  int second_cs;
  int cs_cnt;
  int busy_low;

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    val0  = 8'h00;
    val1  = 8'h00;
    blank = 1'b0;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_cs",   {31'h0, avm_chipselect}, 32'h0);
    check("rst_wn",   {31'h0, avm_write_n}, 32'h1);
    check("rst_wd",   avm_writedata, 32'h0);
    check("rst_acks", {30'h0, ack1, ack0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single request, latency and data
    req0 = 1'b1; val0 = 8'h3A;
    step();
    check("t33_cs",   {31'h0, avm_chipselect}, 32'h1);
    check("t33_wn",   {31'h0, avm_write_n}, 32'h0);
    check("t33_addr", {30'h0, avm_address}, 32'h0);
    check("t33_wd",   avm_writedata, 32'h00004F77);
    check("t33_ack_early", {30'h0, ack1, ack0}, 32'h0);
    step();
    check("t33_ack",  {30'h0, ack1, ack0}, 32'h1);
    check("t33_cs_off", {31'h0, avm_chipselect}, 32'h0);
    req0 = 1'b0;
    step();
    check("t33_gap_busy", {31'h0, busy}, 32'h1);
    check("t33_gap_ack",  {30'h0, ack1, ack0}, 32'h0);
    step();
    check("t33_gap2_busy", {31'h0, busy}, 32'h1);
    step();
    check("t33_idle", {31'h0, busy}, 32'h0);

    // Tie after reset: requester 0 wins first
    reset = 1'b1; #2; reset = 1'b0;
    req0 = 1'b1; val0 = 8'h12;
    req1 = 1'b1; val1 = 8'hEF;
    step();
    check("t34_wd0", avm_writedata, 32'h0000065B);
    step();
    check("t34_ack0", {30'h0, ack1, ack0}, 32'h1);
    req0 = 1'b0;
    step();
    check("t34_gap1", {31'h0, busy}, 32'h1);
    step();
    check("t34_gap2", {31'h0, busy}, 32'h1);
    step();
    check("t34_idle", {31'h0, busy}, 32'h0);
    step();
    check("t34_cs1", {31'h0, avm_chipselect}, 32'h1);
    check("t34_wd1", avm_writedata, 32'h00007971);
    step();
    check("t34_ack1", {30'h0, ack1, ack0}, 32'h2);
    req1 = 1'b0;
    wait_idle();

    // Continuous request spacing
    req0 = 1'b1; val0 = 8'h55;
    first_cs = -1; second_cs = -1; cs_cnt = 0; busy_low = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (avm_chipselect) begin
        cs_cnt++;
        if (first_cs < 0) first_cs = c;
        else if (second_cs < 0) second_cs = c;
      end
      if (!busy && first_cs >= 0 && second_cs < 0) busy_low++;
    end
    req0 = 1'b0;
    check("t35_writes",  cs_cnt, 32'd4);
    check("t35_spacing", second_cs - first_cs, 32'd5);
    check("t35_busylow", busy_low, 32'd1);
    wait_idle();

    // Blanked write
    req1 = 1'b1; val1 = 8'h88; blank = 1'b1;
    step();
    check("t36_cs", {31'h0, avm_chipselect}, 32'h1);
    check("t36_wd", avm_writedata, 32'h0);
    step();
    check("t36_ack1", {30'h0, ack1, ack0}, 32'h2);
    req1 = 1'b0; blank = 1'b0;
    wait_idle();

    // Inputs changing after the latch
    req0 = 1'b1; val0 = 8'h21;
    step();
    check("t38_wd", avm_writedata, 32'h00005B06);
    val0 = 8'hFF; blank = 1'b1;
    step();
    check("t38_wd_hold", avm_writedata, 32'h00005B06);
    check("t38_ack0", {30'h0, ack1, ack0}, 32'h1);
    req0 = 1'b0; blank = 1'b0;
    wait_idle();

    // Reset during WRITE
    req0 = 1'b1; val0 = 8'h01;
    step();
    check("t37_cs_pre", {31'h0, avm_chipselect}, 32'h1);
    #2; reset = 1'b1; #1;
    check("t37_cs_drop", {31'h0, avm_chipselect}, 32'h0);
    check("t37_wn",      {31'h0, avm_write_n}, 32'h1);
    check("t37_busy",    {31'h0, busy}, 32'h0);
    check("t37_wd",      avm_writedata, 32'h0);
    step();
    check("t37_no_ack", {30'h0, ack1, ack0}, 32'h0);
    reset = 1'b0;
    step();
    check("t37_rewrite", avm_writedata, 32'h00003F06);
    check("t37_cs",      {31'h0, avm_chipselect}, 32'h1);
    step();
    check("t37_ack0", {30'h0, ack1, ack0}, 32'h1);
    req0 = 1'b0;
    wait_idle();

    // Tie after requester 0 was granted last: requester 1 wins, then 0 follows
    req0 = 1'b1; val0 = 8'h00;
    req1 = 1'b1; val1 = 8'h11;
    step();
    check("rr_wd1", avm_writedata, 32'h00000606);
    step();
    check("rr_ack1", {30'h0, ack1, ack0}, 32'h2);
    req1 = 1'b0;
    step();
    step();
    step();
    check("rr_idle", {31'h0, busy}, 32'h0);
    step();
    check("rr_wd0", avm_writedata, 32'h00003F3F);
    step();
    check("rr_ack0", {30'h0, ack1, ack0}, 32'h1);
    req0 = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
